// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: loads round key K_r and streams K_r, K_(r-1) .. K0
// over a valid/ready handshake, recovering each earlier key from the current one.
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         err
);
    localparam logic [3:0] NR_W = 4'(NR);

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic         r_err, w_err_nxt;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot, w_sub;
    logic [7:0]   w_rcon;
    logic [127:0] w_prev_key;

    // Byte x sits at bit 2047-8x, which is {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign w_p3   = w_w3 ^ w_w2;
    assign w_p2   = w_w2 ^ w_w1;
    assign w_p1   = w_w1 ^ w_w0;
    assign w_rot  = {w_p3[23:0], w_p3[31:24]};
    assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_rcon = rcon(r_round);
    assign w_p0   = w_w0 ^ w_sub ^ {w_rcon, 24'h0};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_round <= NR_W) begin
                        w_key_nxt   = key_in;
                        w_round_nxt = in_round;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (r_round != 4'd0) begin
                        w_key_nxt   = w_prev_key;
                        w_round_nxt = r_round - 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign rk_out    = r_key;
    assign rk_round  = r_round;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: reference keys come from a GF(2^8)
// derived S-box and the AES key-expansion rules, with random keys and backpressure.
module tb_aes_inv_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   in_round = '0;
    logic         in_ready, out_valid, err;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int checks = 0;
    int errors = 0;
    logic [7:0]   sb [256];
    logic [127:0] obs_key [11];

    localparam logic [127:0] K10 = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
    localparam logic [127:0] K9  = 128'hBFE2BF904559FAB2A16480B4F7F1CBD8;
    localparam logic [127:0] K2  = 128'h56082007C71AB18F76435569A03AF7FA;
    localparam logic [127:0] K1  = 128'hE232FCF191129188B159E4E6D679A293;
    localparam logic [127:0] K0  = 128'h5468617473206D79204B756E67204675;

    always #5 clk = ~clk;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key_in(key_in), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .rk_out(rk_out), .rk_round(rk_round), .err(err)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the AES affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input int i);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < i; j++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        logic [31:0] t;
        t = {w[23:0], w[31:24]};
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int i);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ subrot(k[31:0]) ^ {rcon_ref(i), 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo fwd_step: each later word is the XOR of two neighbouring words.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input int i);
        logic [31:0] q1, q2, q3;
        q3 = k[31:0] ^ k[63:32];
        q2 = k[63:32] ^ k[95:64];
        q1 = k[95:64] ^ k[127:96];
        return {k[127:96] ^ subrot(q3) ^ {rcon_ref(i), 24'h0}, q1, q2, q3};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: out_ready always 1; mode 1: random. noise drives spurious loads during EMIT.
    task automatic run_seq(input string tag, input logic [127:0] key, input int rnd,
                           input int mode, input bit noise);
        logic [127:0] exp_k [11];
        int idx, cyc;
        bit done;
        exp_k[rnd] = key;
        for (int i = rnd; i > 0; i--) exp_k[i-1] = inv_step(exp_k[i], i);
        @(negedge clk);
        chk({tag, " ready_before_load"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1; key_in = key; in_round = 4'(rnd); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        idx = rnd; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            chk({tag, " out_valid"}, 128'(out_valid), 128'(1));
            chk({tag, " rk_out"}, rk_out, exp_k[idx]);
            chk({tag, " rk_round"}, 128'(rk_round), 128'(idx));
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                in_round = 4'($urandom_range(0, 15));
            end
            if (out_ready) begin
                obs_key[idx] = rk_out;
                if (idx == 0) done = 1'b1;
                else idx--;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk({tag, " completed"}, 128'(done), 128'(1));
        if (mode == 0) chk({tag, " cycles"}, 128'(cyc), 128'(rnd + 1));
        chk({tag, " out_valid_after"}, 128'(out_valid), 128'(0));
        chk({tag, " in_ready_after"}, 128'(in_ready), 128'(1));
    endtask

    task automatic bad_load(input logic [3:0] r);
        @(negedge clk);
        in_valid = 1'b1; in_round = r; key_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        chk("err pulse", 128'(err), 128'(1));
        chk("err out_valid", 128'(out_valid), 128'(0));
        chk("err in_ready", 128'(in_ready), 128'(1));
        chk("err rk_out", rk_out, 128'(0));
        chk("err rk_round", 128'(rk_round), 128'(0));
        @(negedge clk);
        chk("err one cycle", 128'(err), 128'(0));
        chk("err still idle", 128'(out_valid), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        #1;
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset err", 128'(err), 128'(0));
        chk("reset rk_out", rk_out, 128'(0));
        chk("reset rk_round", 128'(rk_round), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        bad_load(4'd11);
        bad_load(4'd15);

        run_seq("k10 full", K10, 10, 0, 1'b0);
        chk("k10 round9", obs_key[9], K9);
        chk("k10 round2", obs_key[2], K2);
        chk("k10 round1", obs_key[1], K1);
        chk("k10 round0", obs_key[0], K0);
        for (int r = 0; r < 10; r++)
            chk($sformatf("expand r%0d", r + 1), fwd_step(obs_key[r], r + 1), obs_key[r + 1]);

        run_seq("k10 backpressure", K10, 10, 1, 1'b1);
        run_seq("k1 load", K1, 1, 0, 1'b0);
        chk("k1 round1", obs_key[1], K1);
        chk("k1 round0", obs_key[0], K0);
        run_seq("k0 load", K0, 0, 1, 1'b0);

        // Asynchronous reset in the middle of a stalled sequence.
        @(negedge clk);
        in_valid = 1'b1; key_in = K10; in_round = 4'd10; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset out_valid", 128'(out_valid), 128'(1));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 128'(out_valid), 128'(0));
        chk("async in_ready", 128'(in_ready), 128'(1));
        chk("async rk_out", rk_out, 128'(0));
        chk("async rk_round", 128'(rk_round), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("after reset", K2, 2, 0, 1'b0);

        for (int t = 0; t < 8; t++)
            run_seq($sformatf("random %0d", t), {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 10), 1, 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
